// File: rtl/wb_gpio_pkg.sv
// rtl/wb_gpio_pkg.sv - register offsets and byte-lane merge helper for wb_gpio_irq
package wb_gpio_pkg;

  localparam logic [2:0] REG_DATA_OUT   = 3'd0;
  localparam logic [2:0] REG_DIR        = 3'd1;
  localparam logic [2:0] REG_DATA_IN    = 3'd2;
  localparam logic [2:0] REG_IRQ_EN     = 3'd3;
  localparam logic [2:0] REG_IRQ_EDGE   = 3'd4;
  localparam logic [2:0] REG_IRQ_STATUS = 3'd5;
  localparam logic [2:0] REG_OUT_SET    = 3'd6;
  localparam logic [2:0] REG_OUT_CLR    = 3'd7;

  // Byte lanes with sel = 0 keep the old value.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = sel[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - pad input synchroniser with previous-sample register and edge outputs
module gpio_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pad,
  output logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= pad;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign data_in = sync_q[SYNC_STAGES-1];
  assign rise    = data_in & ~prev;
  assign fall    = ~data_in & prev;

endmodule

// File: rtl/wb_gpio_irq.sv
// rtl/wb_gpio_irq.sv - Wishbone classic GPIO slave with per-bit direction and edge interrupts
module wb_gpio_irq
  import wb_gpio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq_o
);

  logic [WIDTH-1:0] data_out, dir, irq_en, irq_edge, irq_status;
  logic [WIDTH-1:0] data_in, rise, fall, hit, status_cleared;
  logic [31:0]      out_ext, status_ext, rd_data;
  logic [2:0]       reg_sel;
  logic             req, wr;
  logic             unused_adr;

  gpio_sync_edge #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .clock   (clock),
    .reset   (reset),
    .pad     (gpio_i),
    .data_in (data_in),
    .rise    (rise),
    .fall    (fall)
  );

  assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};
  assign reg_sel    = wb_adr_i[4:2];
  assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr         = req & wb_we_i;
  assign out_ext    = 32'(data_out);
  assign status_ext = 32'(irq_status);
  assign hit        = (irq_edge & rise) | (~irq_edge & fall);

  // A same-cycle hit is ORed in after the clear so the new event is never lost.
  always_comb begin
    status_cleared = irq_status;
    if (wr && reg_sel == REG_IRQ_STATUS)
      status_cleared = WIDTH'(apply_sel(status_ext, status_ext & ~wb_dat_i, wb_sel_i));
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_DATA_OUT:   rd_data = out_ext;
      REG_DIR:        rd_data = 32'(dir);
      REG_DATA_IN:    rd_data = 32'(data_in);
      REG_IRQ_EN:     rd_data = 32'(irq_en);
      REG_IRQ_EDGE:   rd_data = 32'(irq_edge);
      REG_IRQ_STATUS: rd_data = status_ext;
      default:        rd_data = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out   <= RESET_OUT;
      dir        <= RESET_DIR;
      irq_en     <= '0;
      irq_edge   <= '0;
      irq_status <= '0;
      irq_o      <= 1'b0;
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
    end else begin
      wb_ack_o   <= req;
      wb_dat_o   <= (req && !wb_we_i) ? rd_data : 32'd0;
      irq_status <= status_cleared | hit;
      irq_o      <= |(irq_status & irq_en);
      if (wr) begin
        case (reg_sel)
          REG_DATA_OUT: data_out <= WIDTH'(apply_sel(out_ext, wb_dat_i, wb_sel_i));
          REG_DIR:      dir      <= WIDTH'(apply_sel(32'(dir), wb_dat_i, wb_sel_i));
          REG_IRQ_EN:   irq_en   <= WIDTH'(apply_sel(32'(irq_en), wb_dat_i, wb_sel_i));
          REG_IRQ_EDGE: irq_edge <= WIDTH'(apply_sel(32'(irq_edge), wb_dat_i, wb_sel_i));
          REG_OUT_SET:  data_out <= WIDTH'(apply_sel(out_ext, out_ext | wb_dat_i, wb_sel_i));
          REG_OUT_CLR:  data_out <= WIDTH'(apply_sel(out_ext, out_ext & ~wb_dat_i, wb_sel_i));
          default:      ;
        endcase
      end
    end
  end

  assign gpio_o   = data_out;
  assign gpio_oe  = dir;
  assign wb_err_o = 1'b0;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// tb/tb_wb_gpio_irq.sv - scoreboard bench for wb_gpio_irq
module tb_wb_gpio_irq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i  = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [7:0]  gpio_i = '0;
  logic [7:0]  gpio_o;
  logic [7:0]  gpio_oe;
  logic        irq_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q [$];
  logic        irq_at_ack;

  wb_gpio_irq #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .RESET_OUT   (8'hA5),
    .RESET_DIR   (8'h0F)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .gpio_i   (gpio_i),
    .gpio_o   (gpio_o),
    .gpio_oe  (gpio_oe),
    .irq_o    (irq_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 one cycle after the ack.
  task automatic wb_cycle(input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic we, input logic [31:0] exp_rd);
    int waited = 0;
    if (!we) exp_q.push_back(exp_rd);
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    do begin
      tick(1);
      waited++;
    end while (!wb_ack_o && waited < 10);
    check("ack_latency", waited, 1);
    irq_at_ack = irq_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick(1);
    check("ack_width", {31'd0, wb_ack_o}, 0);
  endtask

  always @(posedge clock) begin
    #1;
    if (wb_ack_o && !wb_we_i) begin
      if (exp_q.size() == 0) check("sb_unexpected_read", 1, 0);
      else check("rd_data", wb_dat_o, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    tick(2);
    reset = 1'b0;
    tick(1);
    check("rst_oe", gpio_oe, 8'h0F);
    check("rst_out", gpio_o, 8'hA5);
    check("rst_irq", irq_o, 0);
    check("rst_ack", wb_ack_o, 0);
    check("rst_dat", wb_dat_o, 0);
    check("err_tied", wb_err_o, 0);
    wb_cycle(32'h14, 32'h0, 4'hF, 1'b0, 32'h0);

    wb_cycle(32'h00, 32'hFFFF_FF3C, 4'b0001, 1'b1, 0); check("out_write", gpio_o, 8'h3C);
    wb_cycle(32'h18, 32'h01, 4'b0001, 1'b1, 0);        check("out_set", gpio_o, 8'h3D);
    wb_cycle(32'h1C, 32'h0C, 4'b0001, 1'b1, 0);        check("out_clr", gpio_o, 8'h31);
    wb_cycle(32'h18, 32'hFF, 4'b0000, 1'b1, 0);        check("set_nosel", gpio_o, 8'h31);
    wb_cycle(32'h00, 0, 4'hF, 1'b0, 32'h31);
    wb_cycle(32'h18, 0, 4'hF, 1'b0, 32'h0);
    wb_cycle(32'h1C, 0, 4'hF, 1'b0, 32'h0);

    wb_cycle(32'h04, 32'hFFFF_FFFF, 4'hF, 1'b1, 0);    check("dir_all", gpio_oe, 8'hFF);
    wb_cycle(32'h04, 0, 4'hF, 1'b0, 32'hFF);
    wb_cycle(32'h04, 32'h0, 4'b0000, 1'b1, 0);         check("dir_nosel", gpio_oe, 8'hFF);
    wb_cycle(32'h04, 32'h0F, 4'b0001, 1'b1, 0);        check("dir_0f", gpio_oe, 8'h0F);
    wb_cycle(32'h08, 32'hFF, 4'hF, 1'b1, 0);
    wb_cycle(32'h08, 0, 4'hF, 1'b0, 32'h0);

    wb_cycle(32'h0C, 32'h01, 4'b0001, 1'b1, 0);
    wb_cycle(32'h10, 32'h01, 4'b0001, 1'b1, 0);
    gpio_i[0] = 1'b1;
    tick(2);
    check("lat_status_2", dut.irq_status, 0);
    tick(1);
    check("lat_status_3", dut.irq_status, 8'h01);
    check("lat_irq_3", irq_o, 0);
    tick(1);
    check("lat_irq_4", irq_o, 1);
    wb_cycle(32'h08, 0, 4'hF, 1'b0, 32'h01);
    wb_cycle(32'h14, 32'h01, 4'b0001, 1'b1, 0);
    check("irq_at_w1c_ack", irq_at_ack, 1);
    check("irq_after_w1c", irq_o, 0);

    wb_cycle(32'h0C, 32'h0, 4'hF, 1'b1, 0);
    gpio_i[3] = 1'b1;
    tick(5);
    gpio_i[3] = 1'b0;
    tick(5);
    wb_cycle(32'h14, 0, 4'hF, 1'b0, 32'h08);
    check("fall_masked_irq", irq_o, 0);
    wb_cycle(32'h0C, 32'h08, 4'b0001, 1'b1, 0);
    check("fall_enabled_irq", irq_o, 1);

    wb_cycle(32'h0C, 32'h0, 4'hF, 1'b1, 0);
    wb_cycle(32'h14, 32'hFF, 4'b0001, 1'b1, 0);
    gpio_i[0] = 1'b0;
    tick(5);
    wb_cycle(32'h14, 0, 4'hF, 1'b0, 32'h0);
    gpio_i[0] = 1'b1;
    tick(2);
    wb_cycle(32'h14, 32'h01, 4'b0001, 1'b1, 0);
    wb_cycle(32'h14, 0, 4'hF, 1'b0, 32'h01);

    wb_adr_i = 32'h00; wb_dat_i = 32'h5A; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    #2 reset = 1'b1;
    tick(1);
    check("rst_pend_ack", wb_ack_o, 0);
    check("rst_pend_out", gpio_o, 8'hA5);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    reset = 1'b0;
    tick(1);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    tick(1);
    check("rst_mid_ack_hi", wb_ack_o, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_ack_drop", wb_ack_o, 0);
    check("rst_mid_out", gpio_o, 8'hA5);
    check("rst_mid_oe", gpio_oe, 8'h0F);
    check("rst_mid_irq", irq_o, 0);
    tick(1);
    check("rst_hold_ack", wb_ack_o, 0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    reset = 1'b0;
    tick(1);
    wb_cycle(32'h00, 0, 4'hF, 1'b0, 32'hA5);
    wb_cycle(32'h0C, 0, 4'hF, 1'b0, 32'h0);
    wb_cycle(32'h00, 32'h5A, 4'b0001, 1'b1, 0);
    check("retry_out", gpio_o, 8'h5A);

    tick(2);
    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
